// File: rtl/cache_evict_wb.sv
// Victim write-back engine: queues evicted set indices, reads each line from the data
// array word by word, streams the words to memory, then invalidates the line.
// Optional build macro EVICT_SKIP_CLEAN_EN: a line whose word-0 dirty bit is clear is
// invalidated without any memory beats.
module cache_evict_wb #(
  parameter int WORD_WID   = 64,
  parameter int LINE_WORDS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          evict_valid_i,
  input  logic [9:0]                    evict_idx_i,
  output logic                          arr_rd_en_o,
  output logic [9:0]                    arr_rd_idx_o,
  output logic [$clog2(LINE_WORDS)-1:0] arr_rd_word_o,
  input  logic [WORD_WID-1:0]           arr_rd_data_i,
  input  logic                          arr_dirty_i,
  output logic                          mem_wr_valid_o,
  input  logic                          mem_wr_ready_i,
  output logic [9:0]                    mem_wr_idx_o,
  output logic [WORD_WID-1:0]           mem_wr_data_o,
  output logic                          mem_wr_last_o,
  output logic                          inval_o,
  output logic [9:0]                    inval_idx_o,
  output logic                          busy_o,
  output logic [7:0]                    drop_cnt_o
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    INVAL = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [9:0]          fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                fifo_empty_s, fifo_full_s;
  logic                push_s, pop_s, drop_s;
  logic [9:0]          victim_r, victim_s;
  logic [WORD_W-1:0]   word_r, word_s;
  logic [WORD_WID-1:0] data_r, data_s;
  logic                skip_r, skip_s;
  logic [7:0]          drop_cnt_r;
  logic                rd_en_r, rd_en_s;
  logic                wr_valid_r, wr_valid_s;
  logic                wr_last_r, wr_last_s;
  logic                inval_r, inval_s;
  logic                busy_r, busy_s;

  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign fifo_full_s  = (count_r == FULL_CNT);

`ifndef EVICT_SKIP_CLEAN_EN
  logic unused_dirty_s;
  assign unused_dirty_s = arr_dirty_i;
`endif

  // Next-state, capture values and next registered-output decode
  always_comb begin
    state_s  = state_r;
    victim_s = victim_r;
    word_s   = word_r;
    data_s   = data_r;
    skip_s   = skip_r;
    pop_s    = 1'b0;
    case (state_r)
      IDLE, INVAL: begin
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          victim_s = fifo_mem_r[rd_ptr_r];
          word_s   = {WORD_W{1'b0}};
          skip_s   = 1'b0;
          state_s  = READ;
        end else begin
          state_s  = IDLE;
        end
      end
      READ: begin
        state_s = WAIT;
      end
      WAIT: begin
        data_s  = arr_rd_data_i;
`ifdef EVICT_SKIP_CLEAN_EN
        if (word_r == {WORD_W{1'b0}}) begin
          skip_s = ~arr_dirty_i;
        end else begin
          skip_s = skip_r;
        end
`else
        skip_s  = 1'b0;
`endif
        state_s = SEND;
      end
      SEND: begin
        // A clean line spends one cycle here with valid low, then goes straight to INVAL
        if (skip_r) begin
          state_s = INVAL;
        end else if (mem_wr_ready_i) begin
          if (word_r == LAST_WORD) begin
            state_s = INVAL;
          end else begin
            word_s  = word_r + {{(WORD_W-1){1'b0}}, 1'b1};
            state_s = READ;
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Fullness is judged on the count at cycle start, so a same-cycle pop does not rescue a push
    push_s  = evict_valid_i & ~fifo_full_s;
    drop_s  = evict_valid_i & fifo_full_s;
    count_s = count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};

    rd_en_s    = (state_s == READ);
    wr_valid_s = (state_s == SEND) & ~skip_s;
    wr_last_s  = wr_valid_s & (word_s == LAST_WORD);
    inval_s    = (state_s == INVAL);
    busy_s     = (count_s != {CNT_W{1'b0}}) | (state_s != IDLE);
  end

  // Sequencer state, victim/word/data capture and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      victim_r   <= 10'd0;
      word_r     <= {WORD_W{1'b0}};
      data_r     <= {WORD_WID{1'b0}};
      skip_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_last_r  <= 1'b0;
      inval_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      victim_r   <= victim_s;
      word_r     <= word_s;
      data_r     <= data_s;
      skip_r     <= skip_s;
      rd_en_r    <= rd_en_s;
      wr_valid_r <= wr_valid_s;
      wr_last_r  <= wr_last_s;
      inval_r    <= inval_s;
      busy_r     <= busy_s;
    end
  end

  // Victim queue pointers, occupancy and saturating drop counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      drop_cnt_r <= 8'd0;
    end else begin
      count_r <= count_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // Victim queue storage; contents are don't-care while the count is zero
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= evict_idx_i;
    end
  end

  assign arr_rd_en_o    = rd_en_r;
  assign arr_rd_idx_o   = victim_r;
  assign arr_rd_word_o  = word_r;
  assign mem_wr_valid_o = wr_valid_r;
  assign mem_wr_idx_o   = victim_r;
  assign mem_wr_data_o  = data_r;
  assign mem_wr_last_o  = wr_last_r;
  assign inval_o        = inval_r;
  assign inval_idx_o    = victim_r;
  assign busy_o         = busy_r;
  assign drop_cnt_o     = drop_cnt_r;

endmodule

// File: tb/tb_cache_evict_wb.sv
// Bench for cache_evict_wb: a data-array responder, a beat/invalidate logger and a
// line-level reference model that lists the beats each accepted victim must produce.
`timescale 1ns/1ps
module tb_cache_evict_wb;
  localparam int WW  = 64;
  localparam int LW  = 4;
  localparam int FD  = 4;
  localparam int WBW = $clog2(LW);

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           evict_valid_i;
  logic [9:0]     evict_idx_i;
  logic           arr_rd_en_o;
  logic [9:0]     arr_rd_idx_o;
  logic [WBW-1:0] arr_rd_word_o;
  logic [WW-1:0]  arr_rd_data_i;
  logic           arr_dirty_i;
  logic           mem_wr_valid_o;
  logic           mem_wr_ready_i;
  logic [9:0]     mem_wr_idx_o;
  logic [WW-1:0]  mem_wr_data_o;
  logic           mem_wr_last_o;
  logic           inval_o;
  logic [9:0]     inval_idx_o;
  logic           busy_o;
  logic [7:0]     drop_cnt_o;

  cache_evict_wb #(.WORD_WID(WW), .LINE_WORDS(LW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .evict_valid_i(evict_valid_i), .evict_idx_i(evict_idx_i),
    .arr_rd_en_o(arr_rd_en_o), .arr_rd_idx_o(arr_rd_idx_o), .arr_rd_word_o(arr_rd_word_o),
    .arr_rd_data_i(arr_rd_data_i), .arr_dirty_i(arr_dirty_i),
    .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i),
    .mem_wr_idx_o(mem_wr_idx_o), .mem_wr_data_o(mem_wr_data_o), .mem_wr_last_o(mem_wr_last_o),
    .inval_o(inval_o), .inval_idx_o(inval_idx_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [9:0]    idx;
    logic [WW-1:0] data;
    logic          last;
  } beat_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stray_cnt = 0;
  int bb = 0, bi = 0, bs = 0;
  logic [WW-1:0] line_mem [1024][LW];
  logic          line_dirty [1024];
  beat_t         got_q[$];
  beat_t         exp_q[$];
  logic [9:0]    got_inv_q[$];
  int            got_inv_cyc_q[$];
  logic [9:0]    exp_inv_q[$];

  // Data array: read data and dirty bit are valid only in the cycle after the request
  logic           rd_pend = 1'b0;
  logic [9:0]     rd_idx_h;
  logic [WBW-1:0] rd_word_h;
  always @(negedge clk_i) begin
    if (rd_pend === 1'b1) begin
      arr_rd_data_i = line_mem[rd_idx_h][rd_word_h];
      arr_dirty_i   = line_dirty[rd_idx_h];
    end else begin
      arr_rd_data_i = {$urandom, $urandom};
      arr_dirty_i   = 1'($urandom_range(0, 1));
    end
    rd_pend   = arr_rd_en_o;
    rd_idx_h  = arr_rd_idx_o;
    rd_word_h = arr_rd_word_o;
  end

  // Logger of accepted beats, invalidates and out-of-state strobes
  always @(negedge clk_i) begin
    cyc++;
    if (mem_wr_valid_o === 1'b1 && mem_wr_ready_i === 1'b1)
      got_q.push_back('{idx: mem_wr_idx_o, data: mem_wr_data_o, last: mem_wr_last_o});
    if (inval_o === 1'b1) begin
      got_inv_q.push_back(inval_idx_o);
      got_inv_cyc_q.push_back(cyc);
    end
    if ((mem_wr_last_o && !mem_wr_valid_o) || (inval_o && mem_wr_valid_o) ||
        (arr_rd_en_o && (mem_wr_valid_o || inval_o)))
      stray_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; evict_valid_i = 1'b0; evict_idx_i = 10'd0; mem_wr_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    bb = got_q.size(); bi = got_inv_q.size(); bs = stray_cnt;
    exp_q.delete(); exp_inv_q.delete();
  endtask

  task automatic fill_line(input logic [9:0] idx, input logic dirty);
    for (int w = 0; w < LW; w++) line_mem[idx][w] = {$urandom, $urandom};
    line_dirty[idx] = dirty;
  endtask

  // Reference: a written-back line is LW beats in word order, last on the final word,
  // followed by one invalidate; a clean line in skip builds is the invalidate alone.
  task automatic model_line(input logic [9:0] idx);
    bit wb = 1'b1;
`ifdef EVICT_SKIP_CLEAN_EN
    wb = line_dirty[idx];
`endif
    if (wb)
      for (int w = 0; w < LW; w++)
        exp_q.push_back('{idx: idx, data: line_mem[idx][w], last: (w == LW - 1)});
    exp_inv_q.push_back(idx);
  endtask

  task automatic push(input logic [9:0] idx);
    evict_valid_i = 1'b1; evict_idx_i = idx;
    step();
    evict_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy_o === 1'b0) begin ok = 1'b1; break; end
      if (rnd) mem_wr_ready_i = 1'($urandom_range(0, 1));
      step();
    end
    if (rnd) mem_wr_ready_i = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mem_wr_valid_o === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; evict_valid_i = 1'b0; evict_idx_i = 10'd0; mem_wr_ready_i = 1'b0;
    step(); step();
    checks++;
    if ((|{arr_rd_en_o, arr_rd_idx_o, arr_rd_word_o, mem_wr_valid_o, mem_wr_idx_o, mem_wr_data_o,
           mem_wr_last_o, inval_o, inval_idx_o, busy_o, drop_cnt_o}) !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got nonzero/X busy=%b drop=%0d exp all zero", busy_o, drop_cnt_o);
    end
    rst_ni = 1'b1;
    step(); step();
    checks++;
    if ({busy_o, mem_wr_valid_o, arr_rd_en_o, inval_o, drop_cnt_o} !== 12'd0) begin
      errors++; $display("FAIL reset_idle got busy=%b valid=%b rd=%b inval=%b drop=%0d exp 0", busy_o, mem_wr_valid_o, arr_rd_en_o, inval_o, drop_cnt_o);
    end
  endtask

  task automatic test_single();
    int t0; bit ok;
    do_reset();
    mem_wr_ready_i = 1'b1;
    for (int w = 0; w < LW; w++) line_mem[10'h155][w] = WW'(w);
    line_dirty[10'h155] = 1'b1;
    model_line(10'h155);
    t0 = cyc;
    push(10'h155);
    wait_idle(100, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy_o); end
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL single_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
    checks++;
    if (got_inv_q.size() - bi !== 1 || got_inv_q[bi] !== 10'h155) begin
      errors++; $display("FAIL single_inval got count=%0d exp 1 with idx 155", got_inv_q.size() - bi);
    end else begin
      checks++;
      if (got_inv_cyc_q[bi] - t0 !== 3 * LW + 3) begin
        errors++; $display("FAIL single_inval_cycle got=%0d exp=%0d", got_inv_cyc_q[bi] - t0 - 2, 3 * LW + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [9:0] idx; bit ok;
    do_reset();
    idx = 10'($urandom);
    fill_line(idx, 1'b1);
    model_line(idx);
    push(idx);
    wait_valid(32, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_valid_timeout got valid=%b exp 1", mem_wr_valid_o); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_wr_valid_o, mem_wr_last_o, mem_wr_idx_o, mem_wr_data_o} !== {1'b1, 1'b0, idx, line_mem[idx][0]}) begin
        errors++; $display("FAIL stall_hold%0d got valid=%b data=%h exp valid=1 data=%h", i, mem_wr_valid_o, mem_wr_data_o, line_mem[idx][0]);
      end
      step();
    end
    checks++;
    if (got_q.size() - bb !== 0) begin errors++; $display("FAIL stall_no_beat got=%0d exp=0", got_q.size() - bb); end
    mem_wr_ready_i = 1'b1;
    step();
    mem_wr_ready_i = 1'b0;
    checks++;
    if (got_q.size() - bb !== 1 || mem_wr_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_one_beat got beats=%0d valid=%b exp 1 and 0", got_q.size() - bb, mem_wr_valid_o);
    end
    mem_wr_ready_i = 1'b1;
    wait_idle(100, 1'b0, ok);
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL stall_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] idx; bit ok;
    do_reset();
    fill_line(10'd40, 1'b1);
    model_line(10'd40);
    push(10'd40);
    wait_valid(32, ok);
    for (int i = 0; i < 6; i++) begin
      idx = 10'(200 + 11 * i);
      fill_line(idx, 1'b1);
      if (i < FD) model_line(idx);
      evict_valid_i = 1'b1; evict_idx_i = idx;
      step();
    end
    evict_valid_i = 1'b0;
    checks++;
    if (drop_cnt_o !== 8'd2 || busy_o !== 1'b1) begin
      errors++; $display("FAIL b2b_drops got drop=%0d busy=%b exp drop=2 busy=1", drop_cnt_o, busy_o);
    end
    mem_wr_ready_i = 1'b1;
    wait_idle(200, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", busy_o); end
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL b2b_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
    checks++;
    if (got_inv_q.size() - bi !== exp_inv_q.size()) begin
      errors++; $display("FAIL b2b_inval_count got=%0d exp=%0d", got_inv_q.size() - bi, exp_inv_q.size());
    end else foreach (exp_inv_q[i]) begin
      checks++;
      if (got_inv_q[bi+i] !== exp_inv_q[i]) begin errors++; $display("FAIL b2b_inval%0d got=%h exp=%h", i, got_inv_q[bi+i], exp_inv_q[i]); end
    end
  endtask

  task automatic test_drop_sat();
    bit ok;
    do_reset();
    fill_line(10'd50, 1'b1);
    model_line(10'd50);
    push(10'd50);
    wait_valid(32, ok);
    for (int i = 0; i < FD + 256; i++) begin
      if (i < FD) begin fill_line(10'(100 + i), 1'b1); model_line(10'(100 + i)); end
      evict_valid_i = 1'b1; evict_idx_i = 10'(100 + i);
      step();
    end
    evict_valid_i = 1'b0;
    checks++;
    if (drop_cnt_o !== 8'd255) begin errors++; $display("FAIL drop_saturate got=%0d exp=255", drop_cnt_o); end
    mem_wr_ready_i = 1'b1;
    wait_idle(200, 1'b0, ok);
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL sat_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL sat_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
  endtask

  task automatic test_clean();
    int t0; int exp_cyc; bit ok;
    do_reset();
    mem_wr_ready_i = 1'b1;
    fill_line(10'h010, 1'b0);
    model_line(10'h010);
`ifdef EVICT_SKIP_CLEAN_EN
    exp_cyc = 4;
`else
    exp_cyc = 3 * LW + 1;
`endif
    t0 = cyc;
    push(10'h010);
    wait_idle(100, 1'b0, ok);
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL clean_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL clean_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
    checks++;
    if (got_inv_q.size() - bi !== 1 || got_inv_q[bi] !== 10'h010) begin
      errors++; $display("FAIL clean_inval got count=%0d exp 1 with idx 010", got_inv_q.size() - bi);
    end else begin
      checks++;
      if (got_inv_cyc_q[bi] - t0 - 2 !== exp_cyc) begin
        errors++; $display("FAIL clean_inval_cycle got=%0d exp=%0d", got_inv_cyc_q[bi] - t0 - 2, exp_cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    mem_wr_ready_i = 1'b1;
    fill_line(10'h2A7, 1'b1);
    push(10'h2A7);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (got_q.size() - bb == 1 && mem_wr_valid_o === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_reach_beat2 got beats=%0d exp 1 then valid", got_q.size() - bb); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ((|{arr_rd_en_o, arr_rd_idx_o, arr_rd_word_o, mem_wr_valid_o, mem_wr_idx_o, mem_wr_data_o,
           mem_wr_last_o, inval_o, inval_idx_o, busy_o, drop_cnt_o}) !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got valid=%b busy=%b data=%h exp all zero", mem_wr_valid_o, busy_o, mem_wr_data_o);
    end
    do_reset();
    mem_wr_ready_i = 1'b1;
    fill_line(10'h0C3, 1'b1);
    model_line(10'h0C3);
    push(10'h0C3);
    wait_idle(100, 1'b0, ok);
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL rstmid_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
    checks++;
    if (got_inv_q.size() - bi !== 1) begin errors++; $display("FAIL rstmid_inval got=%0d exp=1", got_inv_q.size() - bi); end
  endtask

  task automatic test_random();
    logic [9:0] idx; bit ok; int n;
    do_reset();
    mem_wr_ready_i = 1'b1;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, FD);
      for (int k = 0; k < n; k++) begin
        idx = 10'(b * 128 + k * 17 + $urandom_range(0, 15));
        fill_line(idx, 1'($urandom_range(0, 1)));
        model_line(idx);
        push(idx);
        repeat ($urandom_range(0, 2)) step();
      end
      wait_idle(400, 1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_idle batch%0d got busy=%b exp 0", b, busy_o); end
    end
    checks++;
    if (got_q.size() - bb !== exp_q.size()) begin
      errors++; $display("FAIL rand_beat_count got=%0d exp=%0d", got_q.size() - bb, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[bb+i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[bb+i], exp_q[i]); end
    end
    checks++;
    if (got_inv_q.size() - bi !== exp_inv_q.size()) begin
      errors++; $display("FAIL rand_inval_count got=%0d exp=%0d", got_inv_q.size() - bi, exp_inv_q.size());
    end else foreach (exp_inv_q[i]) begin
      checks++;
      if (got_inv_q[bi+i] !== exp_inv_q[i]) begin errors++; $display("FAIL rand_inval%0d got=%h exp=%h", i, got_inv_q[bi+i], exp_inv_q[i]); end
    end
    checks++;
    if (drop_cnt_o !== 8'd0 || stray_cnt - bs !== 0) begin
      errors++; $display("FAIL rand_drop_stray got drop=%0d stray=%0d exp 0 and 0", drop_cnt_o, stray_cnt - bs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_drop_sat();
    test_clean();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
